// File: rtl/pw_utmi_tx.sv
// pw_utmi_tx: UTMI+ transmit engine. Switches the PHY from non-driving to
// normal opmode, streams a valid/ready byte source (PID first) onto
// fe_data/fe_txvalid under the fe_txready handshake, then holds an
// inter-packet gap before releasing the bus.
// Optional feature macro: PW_UTMI_TX_CRC16_EN (appends CRC16 to data PIDs).
// Ports:
//   fe_clk, reset_n                  clock, async active-low reset
//   I_enable, I_abort                start permit (IDLE only), packet abort
//   I_data, I_valid, I_last, O_ready byte source handshake
//   O_fe_data, O_fe_data_oe          PHY data and its output enable
//   O_fe_txvalid, I_fe_txready       UTMI transmit handshake
//   I_fe_rxactive                    blocks starting a packet
//   O_fe_opmode                      01 non-driving, 00 normal
//   O_busy, O_done, O_error          status, one-cycle pulses
//   O_byte_count                     bytes handed to the PHY, saturating
module pw_utmi_tx #(
  parameter int unsigned pSETTLE_CYCLES = 4,
  parameter int unsigned pIPG_CYCLES    = 8,
  parameter int unsigned pTIMEOUT_WIDTH = 12,
  parameter int unsigned pCOUNT_WIDTH   = 16
) (
  input  logic                    fe_clk,
  input  logic                    reset_n,
  input  logic                    I_enable,
  input  logic                    I_abort,
  input  logic [7:0]              I_data,
  input  logic                    I_valid,
  input  logic                    I_last,
  output logic                    O_ready,
  output logic [7:0]              O_fe_data,
  output logic                    O_fe_data_oe,
  output logic                    O_fe_txvalid,
  input  logic                    I_fe_txready,
  input  logic                    I_fe_rxactive,
  output logic [1:0]              O_fe_opmode,
  output logic                    O_busy,
  output logic                    O_done,
  output logic                    O_error,
  output logic [pCOUNT_WIDTH-1:0] O_byte_count
);

  localparam int unsigned PHASE_MAX = (pSETTLE_CYCLES > pIPG_CYCLES) ? pSETTLE_CYCLES : pIPG_CYCLES;
  localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);

`ifdef PW_UTMI_TX_CRC16_EN
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SEND, S_CRC_LO, S_CRC_HI, S_EOP, S_GAP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SEND, S_EOP, S_GAP} state_t;
`endif

  state_t                    state, state_d;
  logic [1:0]                opmode_d;
  logic [7:0]                fe_data_d;
  logic                      oe_d, txvalid_d, busy_d, done_d, error_d;
  logic [pCOUNT_WIDTH-1:0]   count_d;
  logic                      hold_valid, hold_valid_d;
  logic                      hold_last, hold_last_d;
  logic                      last_taken, last_taken_d;
  logic [PHASE_W-1:0]        pcnt, pcnt_d;
  logic [pTIMEOUT_WIDTH-1:0] tcnt, tcnt_d, tcnt_inc;
  logic                      accept, consume, timeout_hit, count_sat;
`ifdef PW_UTMI_TX_CRC16_EN
  logic [15:0]               crc, crc_d;
  logic                      pid_seen, pid_seen_d;
  logic                      crc_app, crc_app_d;

  // Reflected CRC16 (poly 0xA001), one byte LSB-first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction
`endif

  // Abort takes priority, so a byte offered on an abort cycle is not swallowed.
  assign O_ready     = (state == S_SEND) && !I_abort && !last_taken &&
                       (!hold_valid || (O_fe_txvalid && I_fe_txready));
  assign accept      = I_valid && O_ready;
  assign consume     = O_fe_txvalid && I_fe_txready;
  assign tcnt_inc    = tcnt + pTIMEOUT_WIDTH'(1);
  assign timeout_hit = (tcnt_inc == '1);
  assign count_sat   = (O_byte_count == '1);

  // Next-state and datapath logic.
  always_comb begin
    state_d      = state;
    opmode_d     = O_fe_opmode;
    fe_data_d    = O_fe_data;
    oe_d         = O_fe_data_oe;
    txvalid_d    = O_fe_txvalid;
    done_d       = 1'b0;
    error_d      = 1'b0;
    count_d      = O_byte_count;
    hold_valid_d = hold_valid;
    hold_last_d  = hold_last;
    last_taken_d = last_taken;
    pcnt_d       = pcnt;
    tcnt_d       = tcnt;
`ifdef PW_UTMI_TX_CRC16_EN
    crc_d        = crc;
    pid_seen_d   = pid_seen;
    crc_app_d    = crc_app;
`endif

    case (state)
      S_IDLE: begin
        if (I_enable && I_valid && !I_fe_rxactive) begin
          state_d      = S_SETTLE;
          opmode_d     = 2'b00;
          oe_d         = 1'b1;
          count_d      = '0;
          pcnt_d       = '0;
          tcnt_d       = '0;
          hold_valid_d = 1'b0;
          hold_last_d  = 1'b0;
          last_taken_d = 1'b0;
`ifdef PW_UTMI_TX_CRC16_EN
          crc_d        = 16'hFFFF;
          pid_seen_d   = 1'b0;
          crc_app_d    = 1'b0;
`endif
        end
      end

      S_SETTLE: begin
        if (pcnt == PHASE_W'(pSETTLE_CYCLES - 1)) begin
          state_d = S_SEND;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt + PHASE_W'(1);
        end
      end

      S_SEND: begin
        if (accept) begin
          fe_data_d   = I_data;
          hold_last_d = I_last;
          if (I_last) last_taken_d = 1'b1;
`ifdef PW_UTMI_TX_CRC16_EN
          if (!pid_seen) begin
            pid_seen_d = 1'b1;
            crc_app_d  = (I_data[1:0] == 2'b11);
          end else begin
            crc_d = crc16_byte(crc, I_data);
          end
`endif
        end
        if (consume) begin
          count_d = count_sat ? O_byte_count : O_byte_count + pCOUNT_WIDTH'(1);
          tcnt_d  = '0;
          if (hold_last) begin
            hold_valid_d = 1'b0;
`ifdef PW_UTMI_TX_CRC16_EN
            if (crc_app) begin
              state_d   = S_CRC_LO;
              fe_data_d = ~crc[7:0];
            end else begin
              state_d   = S_EOP;
              txvalid_d = 1'b0;
              oe_d      = 1'b0;
            end
`else
            state_d   = S_EOP;
            txvalid_d = 1'b0;
            oe_d      = 1'b0;
`endif
          end else if (!accept) begin
            // Underrun: PHY took the byte but nothing stands behind it.
            state_d      = S_GAP;
            pcnt_d       = '0;
            error_d      = 1'b1;
            txvalid_d    = 1'b0;
            oe_d         = 1'b0;
            hold_valid_d = 1'b0;
          end else begin
            hold_valid_d = 1'b1;
          end
        end else begin
          if (accept) begin
            hold_valid_d = 1'b1;
            txvalid_d    = 1'b1;
          end
          if (O_fe_txvalid) begin
            tcnt_d = tcnt_inc;
            if (timeout_hit) begin
              state_d      = S_GAP;
              pcnt_d       = '0;
              error_d      = 1'b1;
              txvalid_d    = 1'b0;
              oe_d         = 1'b0;
              hold_valid_d = 1'b0;
            end
          end
        end
      end

`ifdef PW_UTMI_TX_CRC16_EN
      S_CRC_LO, S_CRC_HI: begin
        if (consume) begin
          count_d = count_sat ? O_byte_count : O_byte_count + pCOUNT_WIDTH'(1);
          tcnt_d  = '0;
          if (state == S_CRC_LO) begin
            state_d   = S_CRC_HI;
            fe_data_d = ~crc[15:8];
          end else begin
            state_d   = S_EOP;
            txvalid_d = 1'b0;
            oe_d      = 1'b0;
          end
        end else begin
          tcnt_d = tcnt_inc;
          if (timeout_hit) begin
            state_d   = S_GAP;
            pcnt_d    = '0;
            error_d   = 1'b1;
            txvalid_d = 1'b0;
            oe_d      = 1'b0;
          end
        end
      end
`endif

      S_EOP: begin
        // PHY drops txready once it has finished the EOP.
        if (!I_fe_txready) begin
          state_d = S_GAP;
          pcnt_d  = '0;
          done_d  = 1'b1;
        end else begin
          tcnt_d = tcnt_inc;
          if (timeout_hit) begin
            state_d = S_GAP;
            pcnt_d  = '0;
            error_d = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (pcnt == PHASE_W'(pIPG_CYCLES - 1)) begin
          state_d  = S_IDLE;
          opmode_d = 2'b01;
          pcnt_d   = '0;
        end else begin
          pcnt_d = pcnt + PHASE_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything in the active states, including a last-byte consume.
    if (I_abort && (state != S_IDLE) && (state != S_GAP)) begin
      state_d      = S_GAP;
      pcnt_d       = '0;
      error_d      = 1'b1;
      done_d       = 1'b0;
      txvalid_d    = 1'b0;
      oe_d         = 1'b0;
      hold_valid_d = 1'b0;
      hold_last_d  = 1'b0;
      fe_data_d    = 8'h00;
      count_d      = O_byte_count;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      O_fe_opmode  <= 2'b01;
      O_fe_data    <= 8'h00;
      O_fe_data_oe <= 1'b0;
      O_fe_txvalid <= 1'b0;
      O_busy       <= 1'b0;
      O_done       <= 1'b0;
      O_error      <= 1'b0;
      O_byte_count <= '0;
      hold_valid   <= 1'b0;
      hold_last    <= 1'b0;
      last_taken   <= 1'b0;
      pcnt         <= '0;
      tcnt         <= '0;
`ifdef PW_UTMI_TX_CRC16_EN
      crc          <= 16'hFFFF;
      pid_seen     <= 1'b0;
      crc_app      <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      O_fe_opmode  <= opmode_d;
      O_fe_data    <= fe_data_d;
      O_fe_data_oe <= oe_d;
      O_fe_txvalid <= txvalid_d;
      O_busy       <= busy_d;
      O_done       <= done_d;
      O_error      <= error_d;
      O_byte_count <= count_d;
      hold_valid   <= hold_valid_d;
      hold_last    <= hold_last_d;
      last_taken   <= last_taken_d;
      pcnt         <= pcnt_d;
      tcnt         <= tcnt_d;
`ifdef PW_UTMI_TX_CRC16_EN
      crc          <= crc_d;
      pid_seen     <= pid_seen_d;
      crc_app      <= crc_app_d;
`endif
    end
  end

endmodule
